// File: rtl/poly_pkg.sv
// Shared types and width helpers for the sequential polynomial multiplier.
// Contents: controller state enum, mode encodings, constant functions that
// derive the load-word width, result width, word-counter width and output
// index width from the module parameters.
package poly_pkg;

  typedef enum logic [1:0] {
    StLoadA,
    StLoadB,
    StCompute,
    StOutput
  } state_e;

  localparam bit ModeLin = 1'b0;  // full linear product, 2N-1 coefficients
  localparam bit ModeNeg = 1'b1;  // negacyclic product mod x^N+1, N coefficients

  function automatic int unsigned calc_in_w(input int unsigned cpl, input int unsigned w);
    return cpl * w;
  endfunction

  // Largest linear coefficient is N*(2^W-1)^2, so 2W+log2(N) magnitude bits plus sign.
  function automatic int unsigned calc_rw(input int unsigned n, input int unsigned w);
    return 2 * w + $clog2(n) + 1;
  endfunction

  function automatic int unsigned calc_wcnt_w(input int unsigned n, input int unsigned cpl);
    return (n / cpl > 1) ? $clog2(n / cpl) : 1;
  endfunction

  function automatic int unsigned calc_idx_w(input int unsigned n);
    return $clog2(2 * n);
  endfunction

endpackage

// File: rtl/poly_mac_unit.sv
// Combinational multiply-accumulate step for the polynomial multiplier.
// Ports:
//   acc_i  RW-bit signed running coefficient
//   a_i    W-bit unsigned coefficient of A
//   b_i    W-bit unsigned coefficient of B
//   neg_i  1 = subtract the product (negacyclic wrap), 0 = add
//   sum_o  RW-bit signed acc_i +/- a_i*b_i
module poly_mac_unit #(
  parameter int unsigned W  = 4,
  parameter int unsigned RW = 11
) (
  input  logic [RW-1:0] acc_i,
  input  logic [W-1:0]  a_i,
  input  logic [W-1:0]  b_i,
  input  logic          neg_i,
  output logic [RW-1:0] sum_o
);

  logic [2*W-1:0] prod;
  logic [RW-1:0]  prod_ext;

  always_comb begin
    prod     = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
    prod_ext = {{(RW - 2 * W){1'b0}}, prod};
    sum_o    = neg_i ? (acc_i - prod_ext) : (acc_i + prod_ext);
  end

endmodule

// File: rtl/poly_mult_seq.sv
// Sequential schoolbook polynomial multiplier.
// Loads two N-coefficient unsigned operands CPL coefficients per word, runs one
// MAC per cycle (N*N cycles), then steps result coefficients out on LED.
// Ports:
//   man_clk    clock, rising edge
//   man_reset  asynchronous active-high reset
//   bits       load word, coefficient k at bits[k*W +: W]
//   in_valid   accept a load word (LOAD_A/LOAD_B only)
//   mode       0 linear, 1 negacyclic; latched with the first A word
//   out_ready  advance to the next result coefficient (only while out_valid)
//   busy       high while computing or presenting results
//   out_valid  LED holds a valid coefficient
//   out_idx    index of the coefficient on LED
//   out_last   out_valid and final coefficient
//   LED        signed result coefficient
module poly_mult_seq
  import poly_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 4,
  parameter int unsigned CPL  = 4,
  localparam int unsigned InW  = calc_in_w(CPL, W),
  localparam int unsigned RW   = calc_rw(N, W),
  localparam int unsigned IdxW = calc_idx_w(N)
) (
  input  logic            man_clk,
  input  logic            man_reset,
  input  logic [InW-1:0]  bits,
  input  logic            in_valid,
  input  logic            mode,
  input  logic            out_ready,
  output logic            busy,
  output logic            out_valid,
  output logic [IdxW-1:0] out_idx,
  output logic            out_last,
  output logic [RW-1:0]   LED
);

  localparam int unsigned NumWords = N / CPL;
  localparam int unsigned WcW      = calc_wcnt_w(N, CPL);
  localparam int unsigned IW       = $clog2(N);
  localparam int unsigned CW       = (CPL > 1) ? $clog2(CPL) : 1;
  localparam int unsigned NumAcc   = 2 * N - 1;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q [N];
  logic [W-1:0]    a_d [N];
  logic [W-1:0]    b_q [N];
  logic [W-1:0]    b_d [N];
  logic [RW-1:0]   acc_q [NumAcc];
  logic [RW-1:0]   acc_d [NumAcc];
  logic [WcW-1:0]  wcnt_q, wcnt_d;
  logic [IW-1:0]   i_q, i_d, j_q, j_d;
  logic            mode_q, mode_d;
  logic            valid_q, valid_d;
  logic [IdxW-1:0] idx_q, idx_d, nxt_idx;
  logic [RW-1:0]   led_q, led_d;

  logic [CPL-1:0][W-1:0] word;
  logic [IdxW-1:0] tgt, tgt_eff, last_idx;
  logic            wrap;
  logic [RW-1:0]   mac_sum;

  assign word = bits;

  // i+j < 2N always, so i+j >= N is just the top bit and subtracting N clears it.
  always_comb begin
    tgt      = {1'b0, i_q} + {1'b0, j_q};
    wrap     = (mode_q == ModeNeg) && tgt[IdxW-1];
    tgt_eff  = wrap ? {1'b0, tgt[IdxW-2:0]} : tgt;
    last_idx = (mode_q == ModeLin) ? IdxW'(2 * N - 2) : IdxW'(N - 1);
    nxt_idx  = idx_q + 1'b1;
  end

  poly_mac_unit #(
    .W (W),
    .RW(RW)
  ) u_mac (
    .acc_i(acc_q[tgt_eff]),
    .a_i  (a_q[i_q]),
    .b_i  (b_q[j_q]),
    .neg_i(wrap),
    .sum_o(mac_sum)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    wcnt_d  = wcnt_q;
    i_d     = i_q;
    j_d     = j_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    led_d   = led_q;

    unique case (state_q)
      StLoadA: begin
        if (in_valid) begin
          for (int unsigned k = 0; k < NumWords; k++) begin
            if (wcnt_q == WcW'(k)) begin
              for (int unsigned c = 0; c < CPL; c++) a_d[IW'(k * CPL + c)] = word[CW'(c)];
            end
          end
          if (wcnt_q == '0) mode_d = mode;
          if (wcnt_q == WcW'(NumWords - 1)) begin
            wcnt_d  = '0;
            state_d = StLoadB;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      StLoadB: begin
        if (in_valid) begin
          for (int unsigned k = 0; k < NumWords; k++) begin
            if (wcnt_q == WcW'(k)) begin
              for (int unsigned c = 0; c < CPL; c++) b_d[IW'(k * CPL + c)] = word[CW'(c)];
            end
          end
          if (wcnt_q == WcW'(NumWords - 1)) begin
            wcnt_d  = '0;
            acc_d   = '{default: '0};
            i_d     = '0;
            j_d     = '0;
            state_d = StCompute;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      StCompute: begin
        acc_d[tgt_eff] = mac_sum;
        j_d = j_q + 1'b1;
        if (j_q == IW'(N - 1)) begin
          i_d = i_q + 1'b1;
          if (i_q == IW'(N - 1)) begin
            idx_d   = '0;
            state_d = StOutput;
          end
        end
      end
      StOutput: begin
        // First OUTPUT cycle registers acc[0] onto LED; the last MAC has settled by then.
        if (!valid_q) begin
          valid_d = 1'b1;
          led_d   = acc_q[idx_q];
        end else if (out_ready) begin
          if (idx_q == last_idx) begin
            valid_d = 1'b0;
            idx_d   = '0;
            led_d   = '0;
            state_d = StLoadA;
          end else begin
            idx_d = nxt_idx;
            led_d = acc_q[nxt_idx];
          end
        end
      end
    endcase
  end

  always_ff @(posedge man_clk or posedge man_reset) begin
    if (man_reset) begin
      state_q <= StLoadA;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      acc_q   <= '{default: '0};
      wcnt_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
      mode_q  <= ModeLin;
      valid_q <= 1'b0;
      idx_q   <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      wcnt_q  <= wcnt_d;
      i_q     <= i_d;
      j_q     <= j_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      led_q   <= led_d;
    end
  end

  assign busy      = (state_q == StCompute) || (state_q == StOutput);
  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_last  = valid_q && (idx_q == last_idx);
  assign LED       = led_q;

endmodule

// File: tb/tb_poly_mult_seq.sv
// Scoreboard bench for poly_mult_seq: a CPL=4 instance and a CPL=2 instance,
// both N=4, W=4 (result width 11). Drivers push hand-computed expected
// coefficients; per-instance monitors pop and compare on every accepted output.
module tb_poly_mult_seq;

  localparam int RW = 11;

  typedef struct {
    logic [RW-1:0] led;
    logic [2:0]    idx;
    logic          last;
  } exp_t;

  logic          man_clk = 1'b0;
  logic          man_reset = 1'b0;

  logic [15:0]   bits = '0;
  logic          in_valid = 1'b0, mode = 1'b0, out_ready = 1'b0;
  logic          busy, out_valid, out_last;
  logic [2:0]    out_idx;
  logic [RW-1:0] LED;

  logic [7:0]    bits2 = '0;
  logic          in_valid2 = 1'b0, mode2 = 1'b0, out_ready2 = 1'b0;
  logic          busy2, out_valid2, out_last2;
  logic [2:0]    out_idx2;
  logic [RW-1:0] LED2;

  exp_t exp_q[$];
  exp_t exp2_q[$];
  int   checks = 0;
  int   errors = 0;

  // Hand-computed products. A=x+x^3 (16'h1010), B=1+2x+3x^2+4x^3 (16'h4321).
  int e_lin1[7]  = '{0, 1, 2, 4, 6, 3, 4};
  int e_neg1[7]  = '{-6, -2, -2, 4, 0, 0, 0};
  int e_xlin[7]  = '{225, 450, 675, 900, 675, 450, 225};
  int e_xneg[7]  = '{-450, 0, 450, 900, 0, 0, 0};
  // A=1+2x+3x^2+4x^3 (16'h4321), B=5+x^3 (16'h1005).
  int e_lin2[7]  = '{5, 10, 15, 21, 2, 3, 4};
  int e_neg2[7]  = '{3, 7, 11, 21, 0, 0, 0};
  logic [7:0] words2[4] = '{8'h10, 8'h10, 8'h21, 8'h43};

  always #5 man_clk = ~man_clk;

  poly_mult_seq #(.N(4), .W(4), .CPL(4)) dut (
    .man_clk  (man_clk),
    .man_reset(man_reset),
    .bits     (bits),
    .in_valid (in_valid),
    .mode     (mode),
    .out_ready(out_ready),
    .busy     (busy),
    .out_valid(out_valid),
    .out_idx  (out_idx),
    .out_last (out_last),
    .LED      (LED)
  );

  poly_mult_seq #(.N(4), .W(4), .CPL(2)) dut2 (
    .man_clk  (man_clk),
    .man_reset(man_reset),
    .bits     (bits2),
    .in_valid (in_valid2),
    .mode     (mode2),
    .out_ready(out_ready2),
    .busy     (busy2),
    .out_valid(out_valid2),
    .out_idx  (out_idx2),
    .out_last (out_last2),
    .LED      (LED2)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  task automatic push_exp(input int e[7], input int m, input int cnt, input bit second);
    exp_t x;
    for (int k = 0; k < cnt; k++) begin
      x.led  = RW'(e[k]);
      x.idx  = 3'(k);
      x.last = (k == m - 1);
      if (second) exp2_q.push_back(x);
      else exp_q.push_back(x);
    end
  endtask

  task automatic step();
    @(posedge man_clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w, input logic m);
    bits     = w;
    mode     = m;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // mode is flipped on the B word: only the A-word value may take effect.
  task automatic load_op(input logic [15:0] a, input logic [15:0] b, input logic m);
    send_word(a, m);
    send_word(b, ~m);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
    check("latency", 32'(n), 32'd17);
  endtask

  task automatic wait_last();
    int n = 0;
    while (!out_last && n < 50) begin
      step();
      n++;
    end
    check("out_last_seen", 32'(out_last), 32'd1);
  endtask

  task automatic end_op();
    step();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_idx", 32'(out_idx), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic full_op(input logic [15:0] a, input logic [15:0] b, input logic m,
                         input int e[7]);
    push_exp(e, m ? 4 : 7, m ? 4 : 7, 1'b0);
    out_ready = 1'b1;
    load_op(a, b, m);
    wait_valid();
    wait_last();
    end_op();
  endtask

  initial begin : monitor1
    exp_t x;
    forever begin
      @(negedge man_clk);
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out1_unexpected: idx=%0d led=%0d with nothing expected",
                   out_idx, $signed(LED));
        end else begin
          x = exp_q.pop_front();
          if (LED !== x.led || out_idx !== x.idx || out_last !== x.last) begin
            errors++;
            $display("FAIL out1: got idx=%0d led=%0d last=%b required idx=%0d led=%0d last=%b",
                     out_idx, $signed(LED), out_last, x.idx, $signed(x.led), x.last);
          end
        end
      end
    end
  end

  initial begin : monitor2
    exp_t x;
    forever begin
      @(negedge man_clk);
      if (out_valid2 && out_ready2) begin
        checks++;
        if (exp2_q.size() == 0) begin
          errors++;
          $display("FAIL out2_unexpected: idx=%0d led=%0d with nothing expected",
                   out_idx2, $signed(LED2));
        end else begin
          x = exp2_q.pop_front();
          if (LED2 !== x.led || out_idx2 !== x.idx || out_last2 !== x.last) begin
            errors++;
            $display("FAIL out2: got idx=%0d led=%0d last=%b required idx=%0d led=%0d last=%b",
                     out_idx2, $signed(LED2), out_last2, x.idx, $signed(x.led), x.last);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int n;
    // Reset rises before the first clock edge, so these values prove it is asynchronous.
    #1 man_reset = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_led", 32'(LED), 32'd0);
    check("rst_led2", 32'(LED2), 32'd0);
    step();
    man_reset = 1'b0;
    step();

    full_op(16'h1010, 16'h4321, 1'b0, e_lin1);
    full_op(16'h1010, 16'h4321, 1'b1, e_neg1);
    full_op(16'hFFFF, 16'hFFFF, 1'b0, e_xlin);
    full_op(16'hFFFF, 16'hFFFF, 1'b1, e_xneg);

    // CPL=2: gapped loads, then in_valid held with junk through COMPUTE/OUTPUT.
    push_exp(e_lin1, 7, 7, 1'b1);
    out_ready2 = 1'b1;
    mode2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bits2 = words2[k];
      in_valid2 = 1'b1;
      step();
      if (k < 3) begin
        in_valid2 = 1'b0;
        step();
        step();
      end else begin
        bits2 = 8'hFF;
        mode2 = 1'b1;
      end
    end
    n = 0;
    while (!out_valid2 && n < 200) begin
      step();
      n++;
    end
    check("latency2", 32'(n), 32'd17);
    n = 0;
    while (!out_last2 && n < 50) begin
      step();
      n++;
    end
    check("out_last2_seen", 32'(out_last2), 32'd1);
    in_valid2 = 1'b0;
    step();
    check("idle_busy2", 32'(busy2), 32'd0);
    check("idle_valid2", 32'(out_valid2), 32'd0);
    check("queue2_drained", 32'(exp2_q.size()), 32'd0);
    out_ready2 = 1'b0;

    // Reset mid-COMPUTE.
    out_ready = 1'b0;
    load_op(16'hFFFF, 16'hFFFF, 1'b0);
    for (int k = 0; k < 5; k++) step();
    check("busy_in_compute", 32'(busy), 32'd1);
    man_reset = 1'b1;
    #1;
    check("rstc_busy", 32'(busy), 32'd0);
    check("rstc_valid", 32'(out_valid), 32'd0);
    check("rstc_led", 32'(LED), 32'd0);
    step();
    man_reset = 1'b0;
    step();
    full_op(16'h4321, 16'h1005, 1'b1, e_neg2);

    // Reset mid-OUTPUT after two coefficients have been stepped out.
    out_ready = 1'b0;
    load_op(16'h1010, 16'h4321, 1'b0);
    wait_valid();
    push_exp(e_lin1, 7, 2, 1'b0);
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    check("idx_before_rst", 32'(out_idx), 32'd2);
    man_reset = 1'b1;
    #1;
    check("rsto_busy", 32'(busy), 32'd0);
    check("rsto_valid", 32'(out_valid), 32'd0);
    check("rsto_idx", 32'(out_idx), 32'd0);
    check("rsto_led", 32'(LED), 32'd0);
    check("rsto_drained", 32'(exp_q.size()), 32'd0);
    step();
    man_reset = 1'b0;
    step();
    full_op(16'h4321, 16'h1005, 1'b0, e_lin2);

    // Back-to-back: next A word presented during the final step, mode toggled.
    push_exp(e_lin1, 7, 7, 1'b0);
    out_ready = 1'b1;
    load_op(16'h1010, 16'h4321, 1'b0);
    wait_valid();
    wait_last();
    push_exp(e_neg2, 4, 4, 1'b0);
    bits = 16'h4321;
    mode = 1'b1;
    in_valid = 1'b1;
    step();
    check("b2b_idle", 32'(busy), 32'd0);
    step();
    in_valid = 1'b0;
    send_word(16'h1005, 1'b0);
    wait_valid();
    wait_last();
    end_op();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
